imm_gen_pipe: RTL

IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

---
 rtl/imm_gen_pipe.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/imm_gen_pipe.sv
// RISC-V immediate generator: decodes format, immediate and pc-relative target on accept,
// then holds the result in an output register with an optional skid entry.
module imm_gen_pipe #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned SKID = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_imm,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_target,
    output logic [2:0]      out_fmt,
    output logic            out_illegal,
    output logic [15:0]     illegal_cnt
);

    typedef enum logic [2:0] {
        FMT_NONE  = 3'd0,
        FMT_I     = 3'd1,
        FMT_S     = 3'd2,
        FMT_B     = 3'd3,
        FMT_U     = 3'd4,
        FMT_J     = 3'd5,
        FMT_SHAMT = 3'd6
    } fmt_e;

    typedef struct packed {
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] target;
        fmt_e            fmt;
        logic            illegal;
    } entry_t;

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    fmt_e            dec_fmt;
    logic            dec_illegal;
    logic            dec_pcrel;
    logic [XLEN-1:0] dec_imm;
    entry_t          dec_entry;

    always_comb begin
        opcode      = in_instr[6:0];
        funct3      = in_instr[14:12];
        dec_fmt     = FMT_NONE;
        dec_illegal = 1'b0;
        case (opcode)
            7'b0000011, 7'b1100111: dec_fmt = FMT_I;
            7'b0010011: dec_fmt = (funct3 == 3'b001 || funct3 == 3'b101) ? FMT_SHAMT : FMT_I;
            7'b0011011: begin
                if (XLEN == 64) begin
                    dec_fmt = (funct3 == 3'b001 || funct3 == 3'b101) ? FMT_SHAMT : FMT_I;
                end else begin
                    dec_illegal = 1'b1;
                end
            end
            7'b0100011: dec_fmt = FMT_S;
            7'b1100011: dec_fmt = FMT_B;
            7'b0110111, 7'b0010111: dec_fmt = FMT_U;
            7'b1101111: dec_fmt = FMT_J;
            7'b0110011, 7'b0111011, 7'b0001111, 7'b1110011: dec_fmt = FMT_NONE;
            default: dec_illegal = 1'b1;
        endcase

        case (dec_fmt)
            FMT_I:     dec_imm = XLEN'($signed(in_instr[31:20]));
            FMT_S:     dec_imm = XLEN'($signed({in_instr[31:25], in_instr[11:7]}));
            FMT_B:     dec_imm = XLEN'($signed({in_instr[31], in_instr[7], in_instr[30:25],
                                                in_instr[11:8], 1'b0}));
            FMT_U:     dec_imm = XLEN'($signed({in_instr[31:12], 12'b0}));
            FMT_J:     dec_imm = XLEN'($signed({in_instr[31], in_instr[19:12], in_instr[20],
                                                in_instr[30:21], 1'b0}));
            FMT_SHAMT: dec_imm = (XLEN == 64) ? XLEN'(in_instr[25:20]) : XLEN'(in_instr[24:20]);
            default:   dec_imm = '0;
        endcase

        // AUIPC shares the U format with LUI but is the only U opcode with a target
        dec_pcrel = (dec_fmt == FMT_B) || (dec_fmt == FMT_J) || (opcode == 7'b0010111);

        dec_entry.imm     = dec_imm;
        dec_entry.pc      = in_pc;
        dec_entry.target  = dec_pcrel ? (in_pc + dec_imm) : '0;
        dec_entry.fmt     = dec_fmt;
        dec_entry.illegal = dec_illegal;
    end

    entry_t      out_q, out_d;
    entry_t      skid_q, skid_d;
    logic        out_valid_q, out_valid_d;
    logic        skid_valid_q, skid_valid_d;
    logic [15:0] cnt_q, cnt_d;
    logic        accept;
    logic        pop;

    assign in_ready = (SKID != 0) ? !skid_valid_q : (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;
    assign pop      = out_valid_q && out_ready;

    always_comb begin
        out_d        = out_q;
        skid_d       = skid_q;
        out_valid_d  = out_valid_q;
        skid_valid_d = skid_valid_q;
        cnt_d        = cnt_q;

        if (pop && out_q.illegal && cnt_q != '1) begin
            cnt_d = cnt_q + 16'd1;
        end

        if (flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!out_valid_q || pop) begin
            // Skid is only occupied while in_ready is low, so it never races a new accept
            if (skid_valid_q) begin
                out_d        = skid_q;
                out_valid_d  = 1'b1;
                skid_valid_d = 1'b0;
            end else begin
                out_valid_d = accept;
                if (accept) begin
                    out_d = dec_entry;
                end
            end
        end else if (accept && SKID != 0) begin
            skid_d       = dec_entry;
            skid_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q        <= '0;
            skid_q       <= '0;
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            cnt_q        <= '0;
        end else begin
            out_q        <= out_d;
            skid_q       <= skid_d;
            out_valid_q  <= out_valid_d;
            skid_valid_q <= skid_valid_d;
            cnt_q        <= cnt_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_imm     = out_q.imm;
    assign out_pc      = out_q.pc;
    assign out_target  = out_q.target;
    assign out_fmt     = out_q.fmt;
    assign out_illegal = out_q.illegal;
    assign illegal_cnt = cnt_q;

endmodule
